// File: rtl/led_dimmer_ctrl.sv
// LED dimmer controller: classifies button presses as short (toggle) or long (ramp), drives PWM.
// Optional build macro LED_DIMMER_GAMMA_EN selects a quadratic duty curve instead of linear.
module led_dimmer_ctrl #(
    parameter int W          = 8,
    parameter int LONG_PRESS = 25_000_000,
    parameter int RAMP_DIV   = 100_000,
    parameter int MIN_LEVEL  = 8,
    parameter int INIT_LEVEL = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rise,
    input  logic         fall,
    output logic         pwm,
    output logic         led_on,
    output logic [W-1:0] level,
    output logic         ramping
);

    // state   | meaning
    // IDLE    | waiting for a press
    // PRESSED | button held, timing the press
    // RAMP    | long press in progress, stepping brightness

    localparam int PCW = (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;
    localparam int RCW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [PCW-1:0] PRESS_LAST = PCW'(LONG_PRESS - 1);
    localparam logic [RCW-1:0] RAMP_LAST  = RCW'(RAMP_DIV - 1);
    localparam logic [W-1:0]   LEVEL_MAX  = '1;
    localparam logic [W-1:0]   LEVEL_MIN  = W'(MIN_LEVEL);
    localparam logic [W-1:0]   LEVEL_INIT = W'(INIT_LEVEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        RAMP    = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [PCW-1:0] press_cnt, press_cnt_nxt;
    logic [RCW-1:0] ramp_cnt, ramp_cnt_nxt;
    logic [W-1:0]   level_nxt;
    logic           led_on_nxt;
    logic           ramping_nxt;
    logic           dir_up, dir_up_nxt;
    logic           rise_ok, fall_ok;

    logic [W-1:0]   pwm_cnt;
    logic [W-1:0]   duty;

    // A simultaneous rise and fall is a glitch and neither edge counts.
    assign rise_ok = rise & ~fall;
    assign fall_ok = fall & ~rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            press_cnt <= '0;
            ramp_cnt  <= '0;
            level     <= LEVEL_INIT;
            led_on    <= 1'b0;
            ramping   <= 1'b0;
            dir_up    <= 1'b1;
        end else begin
            state     <= state_nxt;
            press_cnt <= press_cnt_nxt;
            ramp_cnt  <= ramp_cnt_nxt;
            level     <= level_nxt;
            led_on    <= led_on_nxt;
            ramping   <= ramping_nxt;
            dir_up    <= dir_up_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        press_cnt_nxt = press_cnt;
        ramp_cnt_nxt  = ramp_cnt;
        level_nxt     = level;
        led_on_nxt    = led_on;
        ramping_nxt   = ramping;
        dir_up_nxt    = dir_up;

        case (state)
            IDLE: begin
                if (rise_ok) begin
                    state_nxt     = PRESSED;
                    press_cnt_nxt = '0;
                end
            end

            PRESSED: begin
                // Release on the very last count still counts as a short press.
                if (fall_ok) begin
                    led_on_nxt = ~led_on;
                    state_nxt  = IDLE;
                end else if (press_cnt == PRESS_LAST) begin
                    state_nxt    = RAMP;
                    led_on_nxt   = 1'b1;
                    ramp_cnt_nxt = '0;
                    ramping_nxt  = 1'b1;
                end else begin
                    press_cnt_nxt = press_cnt + 1'b1;
                end
            end

            RAMP: begin
                if (fall_ok) begin
                    state_nxt   = IDLE;
                    ramping_nxt = 1'b0;
                    dir_up_nxt  = ~dir_up;
                end else if (ramp_cnt == RAMP_LAST) begin
                    ramp_cnt_nxt = '0;
                    if (dir_up) begin
                        if (level != LEVEL_MAX) begin
                            level_nxt = level + 1'b1;
                        end
                    end else begin
                        if (level > LEVEL_MIN) begin
                            level_nxt = level - 1'b1;
                        end
                    end
                end else begin
                    ramp_cnt_nxt = ramp_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                ramping_nxt = 1'b0;
            end
        endcase
    end

`ifdef LED_DIMMER_GAMMA_EN
    // Quadratic curve: upper half of the 2W-bit square of the level.
    assign duty = W'(({{W{1'b0}}, level} * {{W{1'b0}}, level}) >> W);
`else
    assign duty = level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm     <= led_on && (pwm_cnt < duty);
        end
    end

endmodule

// File: tb/tb_led_dimmer_ctrl.sv
// Scoreboard bench for led_dimmer_ctrl: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_led_dimmer_ctrl;

    localparam int W = 4;
`ifdef LED_DIMMER_GAMMA_EN
    localparam int EXP_DUTY8 = 4;
`else
    localparam int EXP_DUTY8 = 8;
`endif

    localparam int K_STATE  = 0;
    localparam int K_PWMWIN = 1;
    localparam int K_PWMBIT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         rise;
    logic         fall;
    logic         pwm;
    logic         led_on;
    logic [W-1:0] level;
    logic         ramping;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           cyc;
        int           kind;
        logic         on;
        logic [W-1:0] lvl;
        logic         rmp;
        int           cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] hist = '0;

    led_dimmer_ctrl #(
        .W(W), .LONG_PRESS(16), .RAMP_DIV(4), .MIN_LEVEL(2), .INIT_LEVEL(8)
    ) dut (
        .clk(clk), .rst(rst), .rise(rise), .fall(fall),
        .pwm(pwm), .led_on(led_on), .level(level), .ramping(ramping)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_state(input int k, input logic on, input logic [W-1:0] lvl, input logic rmp);
        exp_t e;
        e = '{cyc + k, K_STATE, on, lvl, rmp, 0};
        sb.push_back(e);
    endtask

    task automatic exp_pwmwin(input int k, input int cnt);
        exp_t e;
        e = '{cyc + k, K_PWMWIN, 1'b0, '0, 1'b0, cnt};
        sb.push_back(e);
    endtask

    task automatic exp_pwmbit(input int k, input logic v);
        exp_t e;
        e = '{cyc + k, K_PWMBIT, v, '0, 1'b0, 0};
        sb.push_back(e);
    endtask

    // Monitor: samples outputs at negedge and retires every entry that is due.
    initial begin
        forever begin
            @(negedge clk);
            hist = {hist[14:0], pwm};
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    total++;
                    if (sb[i].cyc < cyc) begin
                        bad++;
                        $display("FAIL stale@%0d: checked at cycle %0d", sb[i].cyc, cyc);
                    end else if (sb[i].kind == K_STATE) begin
                        if ({led_on, level, ramping} !== {sb[i].on, sb[i].lvl, sb[i].rmp}) begin
                            bad++;
                            $display("FAIL state@%0d: got on=%b level=%0d ramping=%b, want on=%b level=%0d ramping=%b",
                                     cyc, led_on, level, ramping, sb[i].on, sb[i].lvl, sb[i].rmp);
                        end
                    end else if (sb[i].kind == K_PWMWIN) begin
                        if ($countones(hist) != sb[i].cnt) begin
                            bad++;
                            $display("FAIL pwm_window@%0d: got %0d high of 16, want %0d",
                                     cyc, $countones(hist), sb[i].cnt);
                        end
                    end else begin
                        if (pwm !== sb[i].on) begin
                            bad++;
                            $display("FAIL pwm_bit@%0d: got %b, want %b", cyc, pwm, sb[i].on);
                        end
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        rise = 1'b0;
        fall = 1'b0;
        tick(3);
        rst = 1'b0;

        // reset state, pwm idle for 40 cycles
        exp_state(1, 1'b0, 4'd8, 1'b0);
        exp_pwmbit(1, 1'b0);
        exp_pwmwin(17, 0);
        exp_pwmwin(40, 0);
        tick(40);

        // short press: LED on, 8/16 duty
        rise = 1'b1;
        exp_state(1, 1'b0, 4'd8, 1'b0);
        exp_state(5, 1'b0, 4'd8, 1'b0);
        tick(1); rise = 1'b0;
        tick(4); fall = 1'b1;
        exp_state(1, 1'b1, 4'd8, 1'b0);
        exp_pwmwin(21, 8);
        tick(1); fall = 1'b0;
        tick(25);

        // second short press: LED off
        rise = 1'b1;
        tick(1); rise = 1'b0;
        tick(4); fall = 1'b1;
        exp_state(1, 1'b0, 4'd8, 1'b0);
        exp_pwmwin(20, 0);
        tick(1); fall = 1'b0;
        tick(25);

        // long press, ramp up 8 -> 11
        rise = 1'b1;
        exp_state(16, 1'b0, 4'd8, 1'b0);
        exp_state(17, 1'b1, 4'd8, 1'b1);
        exp_state(20, 1'b1, 4'd8, 1'b1);
        exp_state(21, 1'b1, 4'd9, 1'b1);
        exp_state(29, 1'b1, 4'd11, 1'b1);
        tick(1); rise = 1'b0;
        tick(29); fall = 1'b1;
        exp_state(1, 1'b1, 4'd11, 1'b0);
        tick(1); fall = 1'b0;
        tick(5);

        // long press down, saturates at MIN_LEVEL
        rise = 1'b1;
        exp_state(17, 1'b1, 4'd11, 1'b1);
        exp_state(21, 1'b1, 4'd10, 1'b1);
        exp_state(49, 1'b1, 4'd3, 1'b1);
        exp_state(53, 1'b1, 4'd2, 1'b1);
        exp_state(150, 1'b1, 4'd2, 1'b1);
        tick(1); rise = 1'b0;
        tick(199); fall = 1'b1;
        exp_state(1, 1'b1, 4'd2, 1'b0);
        tick(1); fall = 1'b0;
        tick(5);

        // long press up, saturates at 15, max duty 15/16
        rise = 1'b1;
        exp_state(17, 1'b1, 4'd2, 1'b1);
        exp_state(21, 1'b1, 4'd3, 1'b1);
        exp_state(65, 1'b1, 4'd14, 1'b1);
        exp_state(69, 1'b1, 4'd15, 1'b1);
        exp_state(150, 1'b1, 4'd15, 1'b1);
        exp_pwmwin(150, 15);
        tick(1); rise = 1'b0;
        tick(199); fall = 1'b1;
        exp_state(1, 1'b1, 4'd15, 1'b0);
        tick(1); fall = 1'b0;
        tick(5);

        // lone fall and rise+fall glitch in IDLE
        fall = 1'b1;
        exp_state(1, 1'b1, 4'd15, 1'b0);
        tick(1); fall = 1'b0;
        tick(2);
        rise = 1'b1; fall = 1'b1;
        exp_state(1, 1'b1, 4'd15, 1'b0);
        exp_state(18, 1'b1, 4'd15, 1'b0);
        tick(1); rise = 1'b0; fall = 1'b0;
        tick(20);

        // glitch during RAMP, then reset mid-ramp
        rise = 1'b1;
        exp_state(17, 1'b1, 4'd15, 1'b1);
        exp_state(20, 1'b1, 4'd15, 1'b1);
        exp_state(21, 1'b1, 4'd14, 1'b1);
        exp_state(23, 1'b1, 4'd14, 1'b1);
        tick(1); rise = 1'b0;
        tick(18); rise = 1'b1; fall = 1'b1;
        tick(1); rise = 1'b0; fall = 1'b0;
        tick(3); rst = 1'b1;
        exp_state(1, 1'b0, 4'd8, 1'b0);
        exp_pwmbit(1, 1'b0);
        exp_pwmwin(20, 0);
        tick(1); rst = 1'b0;
        tick(25);

        // fall on the last press count is still a short press
        rise = 1'b1;
        exp_state(16, 1'b0, 4'd8, 1'b0);
        tick(1); rise = 1'b0;
        tick(15); fall = 1'b1;
        exp_state(1, 1'b1, 4'd8, 1'b0);
        exp_state(2, 1'b1, 4'd8, 1'b0);
        exp_pwmwin(21, EXP_DUTY8);
        tick(1); fall = 1'b0;
        tick(30);

        for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: entry for cycle %0d never checked, now %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
